// File: rtl/i2c_periph_pkg.sv
// Shared types and constants for the I2C target block.
package i2c_periph_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        WAIT_STOP
    } i2c_state_e;

    localparam int   BYTE_BITS = 8;
    localparam logic ACK       = 1'b0;
    localparam logic NACK      = 1'b1;

    // 2-of-3 vote used by the optional bus glitch filter
    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/i2c_periph_sync.sv
// Bus front end: 2-flop synchronizers on scl/sda, optional majority filter
// (enabled by defining I2C_PERIPH_GLITCH_FILTER_EN), edge and START/STOP strobes.
module i2c_periph_sync
    import i2c_periph_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic sda_lvl,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_cur;
    logic       sda_cur;
    logic       scl_prev;
    logic       sda_prev;

    // synchronizers reset to the idle-high bus level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl};
            sda_sync <= {sda_sync[0], sda};
        end
    end

`ifdef I2C_PERIPH_GLITCH_FILTER_EN
    logic [2:0] scl_hist;
    logic [2:0] sda_hist;

    // three-sample history; a level must persist 2 clk to win the vote
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist <= 3'b111;
            sda_hist <= 3'b111;
        end else begin
            scl_hist <= {scl_hist[1:0], scl_sync[1]};
            sda_hist <= {sda_hist[1:0], sda_sync[1]};
        end
    end

    assign scl_cur = maj3(scl_hist);
    assign sda_cur = maj3(sda_hist);
`else
    assign scl_cur = scl_sync[1];
    assign sda_cur = sda_sync[1];
`endif

    // previous filtered levels for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_cur;
            sda_prev <= sda_cur;
        end
    end

    assign sda_lvl  = sda_cur;
    assign scl_rise = scl_cur & ~scl_prev;
    assign scl_fall = ~scl_cur & scl_prev;
    // scl must be high on both samples so an sda change next to an scl edge is not mistaken
    assign start    = scl_cur & scl_prev & sda_prev & ~sda_cur;
    assign stop     = scl_cur & scl_prev & ~sda_prev & sda_cur;

endmodule

// File: rtl/i2c_periph.sv
// I2C target with register-pointer byte access. Bus events come from
// i2c_periph_sync (glitch filter selected by I2C_PERIPH_GLITCH_FILTER_EN).
// Address frame is the byte {addr[6:0], rw}; LSB_FIRST applies to that whole byte.
//
// state     | meaning
// IDLE      | bus free, waiting for START
// ADDR      | shifting in address + R/W
// ADDR_ACK  | driving ACK for matched address
// WR_BYTE   | shifting in a byte from controller
// WR_ACK    | driving ACK for written byte
// RD_BYTE   | driving 8 data bits to controller
// RD_ACK    | sampling controller ACK/NACK
// WAIT_STOP | not addressed or read ended; only START/STOP leave
module i2c_periph
    import i2c_periph_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR  = 7'h42,
    parameter bit         LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    input  logic [7:0] tx,
    output logic [7:0] rx,
    output logic       rw,
    output logic [7:0] reg_addr,
    output logic       rx_valid,
    output logic       tx_req
);

    localparam logic [3:0] LAST_BIT = 4'(BYTE_BITS - 1);

    i2c_state_e state, state_nx;
    logic [3:0] bit_cnt, bit_cnt_nx;
    logic [7:0] shreg, shreg_nx;
    logic       sda_low, sda_low_nx;
    logic [7:0] rx_nx, reg_addr_nx;
    logic       rw_nx, rx_valid_nx, tx_req_nx;
    logic       ptr_phase, ptr_phase_nx;
    logic       sda_lvl, scl_rise, scl_fall, start, stop;
    logic [7:0] rx_byte;

    i2c_periph_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl      (scl),
        .sda      (sda),
        .sda_lvl  (sda_lvl),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    function automatic logic wire_bit(input logic [7:0] b, input logic [2:0] idx);
        return LSB_FIRST ? b[idx] : b[3'd7 - idx];
    endfunction

    assign rx_byte = LSB_FIRST ? {sda_lvl, shreg[7:1]} : {shreg[6:0], sda_lvl};
    assign sda     = sda_low ? 1'b0 : 1'bz;

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            sda_low   <= 1'b0;
            rx        <= '0;
            rw        <= 1'b0;
            reg_addr  <= '0;
            rx_valid  <= 1'b0;
            tx_req    <= 1'b0;
            ptr_phase <= 1'b0;
        end else begin
            state     <= state_nx;
            bit_cnt   <= bit_cnt_nx;
            shreg     <= shreg_nx;
            sda_low   <= sda_low_nx;
            rx        <= rx_nx;
            rw        <= rw_nx;
            reg_addr  <= reg_addr_nx;
            rx_valid  <= rx_valid_nx;
            tx_req    <= tx_req_nx;
            ptr_phase <= ptr_phase_nx;
        end
    end

    // next-state and datapath updates; START/STOP override every state
    always_comb begin
        state_nx     = state;
        bit_cnt_nx   = bit_cnt;
        shreg_nx     = shreg;
        sda_low_nx   = sda_low;
        rx_nx        = rx;
        rw_nx        = rw;
        reg_addr_nx  = reg_addr;
        ptr_phase_nx = ptr_phase;
        rx_valid_nx  = 1'b0;
        tx_req_nx    = 1'b0;
        if (stop) begin
            state_nx   = IDLE;
            sda_low_nx = 1'b0;
        end else if (start) begin
            state_nx   = ADDR;
            bit_cnt_nx = '0;
            sda_low_nx = 1'b0;
        end else begin
            case (state)
                ADDR: if (scl_rise) begin
                    shreg_nx   = rx_byte;
                    bit_cnt_nx = bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) begin
                        if (rx_byte[7:1] == DEV_ADDR) begin
                            rw_nx        = rx_byte[0];
                            ptr_phase_nx = 1'b1;
                            state_nx     = ADDR_ACK;
                        end else begin
                            state_nx = WAIT_STOP;
                        end
                    end
                end
                // first fall starts the ACK drive, second fall ends it
                ADDR_ACK: if (scl_fall) begin
                    if (!sda_low) begin
                        sda_low_nx = 1'b1;
                    end else begin
                        bit_cnt_nx = '0;
                        if (rw) begin
                            state_nx   = RD_BYTE;
                            tx_req_nx  = 1'b1;
                            shreg_nx   = tx;
                            sda_low_nx = ~wire_bit(tx, 3'd0);
                        end else begin
                            state_nx   = WR_BYTE;
                            sda_low_nx = 1'b0;
                        end
                    end
                end
                WR_BYTE: if (scl_rise) begin
                    shreg_nx   = rx_byte;
                    bit_cnt_nx = bit_cnt + 4'd1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nx = WR_ACK;
                        if (ptr_phase) begin
                            reg_addr_nx = rx_byte;
                        end else begin
                            rx_nx       = rx_byte;
                            rx_valid_nx = 1'b1;
                        end
                    end
                end
                WR_ACK: if (scl_fall) begin
                    if (!sda_low) begin
                        sda_low_nx = 1'b1;
                    end else begin
                        sda_low_nx   = 1'b0;
                        state_nx     = WR_BYTE;
                        bit_cnt_nx   = '0;
                        ptr_phase_nx = 1'b0;
                        if (!ptr_phase) reg_addr_nx = reg_addr + 8'd1;
                    end
                end
                RD_BYTE: if (scl_fall) begin
                    if (bit_cnt == LAST_BIT) begin
                        sda_low_nx = 1'b0;
                        bit_cnt_nx = '0;
                        state_nx   = RD_ACK;
                    end else begin
                        bit_cnt_nx = bit_cnt + 4'd1;
                        sda_low_nx = ~wire_bit(shreg, bit_cnt[2:0] + 3'd1);
                    end
                end
                // bit_cnt==1 marks an ACK seen; the next byte starts on the following fall
                RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == ACK) bit_cnt_nx = 4'd1;
                        else                state_nx   = WAIT_STOP;
                    end else if (scl_fall && bit_cnt == 4'd1) begin
                        state_nx    = RD_BYTE;
                        bit_cnt_nx  = '0;
                        reg_addr_nx = reg_addr + 8'd1;
                        tx_req_nx   = 1'b1;
                        shreg_nx    = tx;
                        sda_low_nx  = ~wire_bit(tx, 3'd0);
                    end
                end
                IDLE, WAIT_STOP: ;
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_periph.sv
// Self-checking bench for i2c_periph: bit-banged controller at clk/8,
// weak pull-up on sda, transaction-level reference model.
module tb_i2c_periph;

    localparam logic [6:0] DEV       = 7'h42;
    localparam bit         LSB_FIRST = 1'b1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_drv = 1'b1;
    logic       ctl_sda_low = 1'b0;
    logic [7:0] tx = 8'h00;
    logic [7:0] rx, reg_addr;
    logic       rw, rx_valid, tx_req;
    wire        sda_bus;

    assign sda_bus = ctl_sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_periph #(.DEV_ADDR(DEV), .LSB_FIRST(LSB_FIRST)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl      (scl_drv),
        .sda      (sda_bus),
        .tx       (tx),
        .rx       (rx),
        .rw       (rw),
        .reg_addr (reg_addr),
        .rx_valid (rx_valid),
        .tx_req   (tx_req)
    );

    int n_vec = 0;
    int n_err = 0;
    int rxv_cnt = 0;
    int txr_cnt = 0;
    int tgt_low_cnt = 0;

    // reference model state
    logic [7:0] m_ptr = 8'h00;
    logic [7:0] m_rx  = 8'h00;
    logic       m_rw  = 1'b0;
    int         m_rxv = 0;
    int         m_txr = 0;
    logic [7:0] mem  [256];
    logic [7:0] wbuf [4];

    always @(negedge clk) begin
        if (rx_valid) rxv_cnt++;
        if (tx_req)   txr_cnt++;
    end

    always begin
        @(posedge clk);
        #1;
        if (sda_bus === 1'b0 && !ctl_sda_low) tgt_low_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_state(input string where);
        chk({where, ":reg_addr"}, reg_addr, m_ptr);
        chk({where, ":rx"}, rx, m_rx);
        chk({where, ":rw"}, rw, m_rw);
        chk({where, ":rx_valid_pulses"}, rxv_cnt, m_rxv);
        chk({where, ":tx_req_pulses"}, txr_cnt, m_txr);
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    // START or repeated START; ends with scl low
    task automatic bus_start();
        clk_wait(1); ctl_sda_low = 1'b0;
        clk_wait(4); scl_drv = 1'b1;
        clk_wait(3); ctl_sda_low = 1'b1;
        clk_wait(3); scl_drv = 1'b0;
    endtask

    task automatic bus_stop();
        clk_wait(1); ctl_sda_low = 1'b1;
        clk_wait(4); scl_drv = 1'b1;
        clk_wait(3); ctl_sda_low = 1'b0;
        clk_wait(6);
    endtask

    // one 8-clk bit: 5 clk low, 3 clk high; bus sampled mid-high
    task automatic put_bit(input logic b, output logic seen);
        clk_wait(1); ctl_sda_low = ~b;
        clk_wait(4); scl_drv = 1'b1;
        clk_wait(2); seen = sda_bus;
        clk_wait(1); scl_drv = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        logic s;
        for (int k = 0; k < n; k++) put_bit(LSB_FIRST ? v[k] : v[7-k], s);
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        logic s;
        send_bits(v, 8);
        put_bit(1'b1, s);
        ack = (s == 1'b0);
    endtask

    task automatic recv_byte(output logic [7:0] v);
        logic s;
        v = 8'h00;
        for (int k = 0; k < 8; k++) begin
            put_bit(1'b1, s);
            if (LSB_FIRST) v[k] = s;
            else           v[7-k] = s;
        end
    endtask

    task automatic do_write(input logic [6:0] addr, input int n);
        logic ack;
        bit   match;
        int   low0;
        match = (addr == DEV);
        low0  = tgt_low_cnt;
        bus_start();
        send_byte({addr, 1'b0}, ack);
        chk("wr_addr_ack", ack, match);
        if (match) m_rw = 1'b0;
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], ack);
            chk("wr_data_ack", ack, match);
            if (match) begin
                if (i == 0) m_ptr = wbuf[0];
                else begin
                    m_rx = wbuf[i];
                    m_rxv++;
                    m_ptr++;
                end
            end
        end
        bus_stop();
        if (!match) chk("no_target_drive", tgt_low_cnt, low0);
        chk_state("write");
    endtask

    task automatic do_read(input logic [7:0] ptr, input int n);
        logic       ack, s;
        logic [7:0] b;
        int         low0;
        bus_start();
        send_byte({DEV, 1'b0}, ack);
        chk("rd_waddr_ack", ack, 1'b1);
        send_byte(ptr, ack);
        chk("rd_ptr_ack", ack, 1'b1);
        m_ptr = ptr;
        tx = mem[m_ptr];
        bus_start();
        send_byte({DEV, 1'b1}, ack);
        chk("rd_raddr_ack", ack, 1'b1);
        m_rw = 1'b1;
        m_txr++;
        low0 = 0;
        for (int i = 0; i < n; i++) begin
            recv_byte(b);
            chk("rd_data", b, mem[m_ptr]);
            if (i < n - 1) begin
                m_ptr++;
                m_txr++;
                tx = mem[m_ptr];
                put_bit(1'b0, s);
            end else begin
                put_bit(1'b1, s);
                low0 = tgt_low_cnt;
            end
        end
        bus_stop();
        chk("released_after_nack", tgt_low_cnt, low0);
        chk_state("read");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic       ack, s;
        logic [6:0] bad;
        int         low0;

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        clk_wait(3);
        rst_n = 1'b1;
        clk_wait(4);
        chk("rst_sda", sda_bus, 1'b1);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_tx_req", tx_req, 1'b0);
        chk_state("reset");

        // directed write: pointer 0x67, data 0x66
        wbuf[0] = 8'h67; wbuf[1] = 8'h66;
        do_write(DEV, 2);

        // wrong address
        wbuf[0] = 8'h11;
        do_write(7'h43, 1);

        // read at 0x67, ACK, ACK, NACK
        do_read(8'h67, 3);

        // pointer wrap
        wbuf[0] = 8'hFE; wbuf[1] = 8'h5A; wbuf[2] = 8'hC3;
        do_write(DEV, 3);

        // STOP after 4 data bits
        bus_start();
        send_byte({DEV, 1'b0}, ack);
        chk("p4_addr_ack", ack, 1'b1);
        wbuf[0] = 8'($urandom);
        send_byte(wbuf[0], ack);
        chk("p4_ptr_ack", ack, 1'b1);
        m_ptr = wbuf[0];
        m_rw  = 1'b0;
        send_bits(8'($urandom), 4);
        bus_stop();
        chk_state("partial");
        wbuf[0] = 8'h20; wbuf[1] = 8'($urandom);
        do_write(DEV, 2);

        // randomized mix
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
            case ($urandom_range(0, 2))
                0: do_write(DEV, int'($urandom_range(1, 4)));
                1: begin
                    bad = 7'($urandom);
                    if (bad == DEV) bad = bad ^ 7'h01;
                    do_write(bad, int'($urandom_range(1, 2)));
                end
                default: do_read(8'($urandom), int'($urandom_range(1, 3)));
            endcase
        end

        // reset while target drives the address ACK of a read
        bus_start();
        send_bits({DEV, 1'b1}, 8);
        clk_wait(1); ctl_sda_low = 1'b0;
        clk_wait(4); scl_drv = 1'b1;
        clk_wait(2);
        chk("ack_before_reset", sda_bus, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("sda_at_reset", sda_bus, 1'b1);
        m_ptr = 8'h00; m_rx = 8'h00; m_rw = 1'b0;
        chk("rst2_reg_addr", reg_addr, m_ptr);
        chk("rst2_rx", rx, m_rx);
        chk("rst2_rw", rw, m_rw);
        chk("rst2_tx_req", tx_req, 1'b0);
        chk("rst2_rx_valid", rx_valid, 1'b0);
        clk_wait(3);
        rst_n = 1'b1;
        clk_wait(6);
        low0 = tgt_low_cnt;
        chk("idle_after_reset", tgt_low_cnt, low0);
        chk_state("after_reset");

        wbuf[0] = 8'($urandom); wbuf[1] = 8'($urandom);
        do_write(DEV, 2);
        put_bit(1'b1, s);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
